// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and limits for the N-to-1 registered stream multiplexer.
package stream_mux_pkg;
  typedef enum logic {MODE_SELECT = 1'b0, MODE_RR = 1'b1} mux_mode_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
  localparam int MAX_N = 16;
  localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/stream_mux_nx1_if.sv
// stream_mux_nx1_if: N input streams, select/mode controls and one output stream.
interface stream_mux_nx1_if #(parameter int N = 4, parameter int WIDTH = 32);
  localparam int SW = $clog2(N);
  logic [WIDTH-1:0] in_data [N-1:0];
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [SW-1:0] sel;
  logic mode;
  logic [WIDTH-1:0] out_data;
  logic [SW-1:0] out_src;
  logic out_valid;
  logic out_ready;
  modport slave (input in_data, in_valid, sel, mode, out_ready,
                 output in_ready, out_data, out_src, out_valid);
  modport master (output in_data, in_valid, sel, mode, out_ready,
                  input in_ready, out_data, out_src, out_valid);
endinterface

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// rr_arbiter: combinational round-robin search for the first request at or above ptr, wrapping at N.
module rr_arbiter #(parameter int N = 4, parameter int SW = $clog2(N)) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_grant_valid,
  output logic [SW-1:0] o_idx
);
  always_comb begin
    o_grant_valid = 1'b0;
    o_idx = '0;
    // Scan farthest offset first so the nearest request to ptr wins last.
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_grant_valid = 1'b1;
        o_idx = SW'((int'(i_ptr) + k) % N);
      end
  end
  assign o_grant = o_grant_valid ? N'(1) << o_idx : '0;
endmodule

// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: registered N-to-1 stream mux with source tag; STREAM_MUX_RR_EN adds round-robin mode.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(parameter int N = 4, parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  stream_mux_nx1_if.slave bus
);
  localparam int SW = $clog2(N);
  out_state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0] r_src, w_g;
  logic w_load_en, w_gv, w_sel_gv, w_xfer;
  logic [N-1:0] w_onehot;
  assign w_load_en = r_state == OUT_EMPTY || bus.out_ready;
  assign w_sel_gv = int'(bus.sel) < N;
`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] r_ptr, w_rr_idx;
  logic [N-1:0] w_rr_grant;
  logic w_rr_gv, w_rr;
  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .i_req(bus.in_valid),
    .i_ptr(r_ptr),
    .o_grant(w_rr_grant),
    .o_grant_valid(w_rr_gv),
    .o_idx(w_rr_idx)
  );
  assign w_rr = mux_mode_t'(bus.mode) == MODE_RR;
  assign w_g = w_rr ? w_rr_idx : bus.sel;
  assign w_gv = w_rr ? w_rr_gv : w_sel_gv;
  assign w_onehot = w_rr ? w_rr_grant : N'(1) << bus.sel;
  always_ff @(posedge clk)
    if (!rst_n) r_ptr <= '0;
    else if (w_xfer && w_rr) r_ptr <= (int'(w_g) == N - 1) ? '0 : w_g + 1'b1;
`else
  assign w_g = bus.sel;
  assign w_gv = w_sel_gv;
  assign w_onehot = N'(1) << bus.sel;
`endif
  assign bus.in_ready = (rst_n && w_load_en && w_gv) ? w_onehot : '0;
  assign w_xfer = |(bus.in_ready & bus.in_valid);
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) w_state_nxt = OUT_FULL;
    else if (r_state == OUT_FULL && bus.out_ready) w_state_nxt = OUT_EMPTY;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= OUT_EMPTY;
      r_data <= '0;
      r_src <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_data <= bus.in_data[w_g];
        r_src <= w_g;
      end
    end
  assign bus.out_data = r_data;
  assign bus.out_src = r_src;
  assign bus.out_valid = r_state == OUT_FULL;
endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb_stream_mux_nx1: directed stimulus with a scoreboard queue checked by a decoupled output monitor.
module tb_stream_mux_nx1;
  typedef struct packed {logic [31:0] d; logic [1:0] s;} beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  beat_t sb[$];
  stream_mux_nx1_if #(.N(4), .WIDTH(32)) bus ();
  stream_mux_nx1 #(.N(4), .WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s);
    sb.push_back('{d: d, s: s});
  endtask

  task automatic set_data(input logic [31:0] d0, d1, d2, d3);
    bus.in_data[0] = d0;
    bus.in_data[1] = d1;
    bus.in_data[2] = d2;
    bus.in_data[3] = d3;
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data=%0d src=%0d expected none", bus.out_data, bus.out_src);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 64'(bus.out_data), 64'(e.d));
        chk("beat_src", 64'(bus.out_src), 64'(e.s));
      end
    end
  end

  initial begin
    set_data(10, 11, 12, 13);
    bus.in_valid = 4'hF;
    bus.sel = 2'd0;
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    chk("in_ready_in_reset", 64'(bus.in_ready), 64'h0);
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_src", 64'(bus.out_src), 64'd0);
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #0 chk("sel_in_ready", 64'(bus.in_ready), 64'(4'b1 << s));
      push(32'(10 + s), 2'(s));
      step();
    end
    bus.sel = 2'd2;
    push(12, 2);
    step();
    bus.out_ready = 1'b0;
    bus.in_data[2] = 99;
    for (int c = 0; c < 3; c++) begin
      #0 chk("bp_out_data", 64'(bus.out_data), 64'd12);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
      step();
    end
    bus.out_ready = 1'b1;
    #0 chk("bp_release_in_ready", 64'(bus.in_ready), 64'b0100);
    push(99, 2);
    step();
    bus.in_valid = 4'h0;
    step();
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_out_data_held", 64'(bus.out_data), 64'd99);
    set_data(10, 11, 12, 13);
`ifdef STREAM_MUX_RR_EN
    bus.mode = 1'b1;
    bus.in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #0 chk("rr_in_ready", 64'(bus.in_ready), 64'(4'b1 << (k % 4)));
      push(32'(10 + k % 4), 2'(k % 4));
      step();
    end
    bus.in_valid = 4'b1010;
    push(11, 1);
    step();
    push(13, 3);
    step();
    push(11, 1);
    step();
    bus.in_valid = 4'h0;
    #0 chk("rr_none_in_ready", 64'(bus.in_ready), 64'h0);
    step();
    chk("rr_drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rr_drain_out_data", 64'(bus.out_data), 64'd11);
`endif
    bus.mode = 1'b0;
    bus.sel = 2'd2;
    bus.in_valid = 4'hF;
    push(12, 2);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 4'h0;
    chk("pre_rst_out_data", 64'(bus.out_data), 64'd12);
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    step();
    sb.delete();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(bus.out_data), 64'd0);
    chk("mid_rst_out_src", 64'(bus.out_src), 64'd0);
    bus.in_valid = 4'hF;
    bus.mode = 1'b1;
`ifdef STREAM_MUX_RR_EN
    #0 chk("post_rst_rr_grant", 64'(bus.in_ready), 64'b0001);
    push(10, 0);
    step();
`else
    bus.sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #0 chk("norr_in_ready", 64'(bus.in_ready), 64'b1000);
      push(13, 3);
      step();
    end
`endif
    bus.in_valid = 4'h0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_mux_nx1.md
# stream_mux_nx1

Parametrised N-input, WIDTH-bit registered stream multiplexer with valid/ready handshakes on every port. Successor to the combinational 4x1 word selector: it adds a registered output stage, back-pressure, a source tag and an optional round-robin arbitration mode. It sits between producer stages (ALU/memory result paths) and a single consumer, such as the write-back or output port.

## Interface
- `N`, 4: number of input channels, 2..16.
- `WIDTH`, 32: data width in bits, 1..64.
- `SW`, `$clog2(N)`: select/tag width. Derived; do not override.

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in_data`  in  N x WIDTH: per-channel data, unpacked array `[N-1:0]`.
- `in_valid`  in  N: per-channel valid.
- `in_ready`  out  N: per-channel ready, at most one bit high (one-hot or zero).
- `sel`  in  SW: channel index used in SELECT mode.
- `mode`  in  1: 0 = SELECT, 1 = ROUND_ROBIN.
- `out_data`  out  WIDTH: registered output data.
- `out_src`  out  SW: index of the channel that supplied `out_data`.
- `out_valid`  out  1: output holds a beat.
- `out_ready`  in  1: consumer accepts the beat.

## Operation
- Output register has two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load_en` = EMPTY, or (FULL and `out_ready`). This gives a pass-through pipeline with 1 beat/cycle sustained.
- Grant `g`, combinational:
  - SELECT: `g`=`sel`. If `sel` >= N, there is no grant.
  - ROUND_ROBIN: `g` is the lowest index i such that `in_valid[i]`, searching from `ptr` upward with wrap at N. If no channel is valid, there is no grant.
- `in_ready[i]` = `load_en` && grant exists && i==`g`. `in_ready` is independent of `in_valid[g]` in SELECT mode.
- A transfer on channel g occurs when `in_valid[g]` && `in_ready[g]`. On the next edge:
  - `out_data` <= `in_data[g]`, `out_src` <= g, state goes to FULL.
  - ROUND_ROBIN only: `ptr` <= (g+1) mod N.
- When FULL && `out_ready` and no transfer occurs: state goes to EMPTY. `out_data` and `out_src` keep their last values.
- When FULL && !`out_ready`: `out_data`, `out_src` and `out_valid` are held stable, and all `in_ready` are 0.
- `mode` or `sel` may change on any cycle; the change takes effect the same cycle. `ptr` is not modified in SELECT mode.
- Reset (`rst_n`=0 at an edge) applies at any point, including mid-stream. It sets `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0, and drops any held beat. While `rst_n`=0, all `in_ready` are 0.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready`=1.
- Simultaneous output drain and input load in one cycle: state stays FULL with the new beat.
- Combinational paths: `out_ready` to `in_ready` (one gate level), and `in_valid` to `in_ready` (ROUND_ROBIN priority search). There is no path from in_* to out_*.
- First edge after `rst_n` rises: the block can accept a transfer in that cycle.

## Configuration
- `STREAM_MUX_RR_EN` defined: ROUND_ROBIN mode, the `ptr` register and the priority search are compiled in.
- `STREAM_MUX_RR_EN` undefined:
  - The `mode` port remains but is ignored and treated as 0 (SELECT).
  - No `ptr` register exists; there is no arbitration logic.

## Structure
- Package `stream_mux_pkg`:
  - `typedef enum logic {MODE_SELECT=1'b0, MODE_RR=1'b1} mux_mode_t`
  - `typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t`
  - localparams `MAX_N=16`, `MAX_WIDTH=64`
- Sub-module `rr_arbiter`: N-bit request vector plus `ptr` in; one-hot grant, `grant_valid` and encoded index out. Purely combinational.
- The `ptr` register lives in `stream_mux_nx1`.

## Test plan
- Reset and SELECT path:
  - Stimulus: reset 2 cycles, mode=0, N=4, WIDTH=32, `in_data` = {13,12,11,10}, all valid, `out_ready`=1, `sel` stepping 0..3.
  - Response: `out_data` = 10,11,12,13 one cycle after each `sel` value, `out_src` = `sel`, `in_ready` = one-hot of `sel`.
- Back-pressure:
  - Stimulus: `sel`=2, `out_ready`=0 for 3 cycles, `in_data[2]` changed to 99 meanwhile.
  - Response: `out_data` stays 12, all `in_ready`=0. Releasing `out_ready` yields 99 on the next cycle.
- Round-robin fairness (macro defined):
  - Stimulus: mode=1, all `in_valid`=1, `out_ready`=1.
  - Response: `out_src` sequence 0,1,2,3,0 on consecutive cycles.
- Round-robin skip:
  - Stimulus: only channels 1 and 3 valid.
  - Response: `out_src` alternates 1,3,1. Then all valid dropped: `out_valid` falls after 1 cycle and `out_data` is held.
- Reset mid-stream:
  - Stimulus: FULL with `out_data`=12, `rst_n`=0 for 1 edge.
  - Response: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0. The next RR grant with all valid is channel 0.
- Macro undefined:
  - Stimulus: mode=1, `sel`=3.
  - Response: behaves as SELECT, `out_src`=3 on every beat.
